// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx stop-bit path: state encoding, the
// vote-window offsets around bit centre, and the parameter range limits.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } uart_stop_state_t;

    // Votes are taken at centre-1, centre and centre+1 oversample ticks.
    localparam int VOTE_OFFSET = 1;

    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 4;
    localparam int OSR_MIN       = 4;

    function automatic int vote_centre(input int osr);
        return osr / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_stop_check_if.sv
// Handshake and line signals between the uart_rx data-bit stage and the
// stop-bit checker; slave is the checker side.
interface uart_stop_check_if;

    logic i_en;
    logic i_rx;
    logic i_start;
    logic i_data_zero;
    logic o_ready;
    logic o_frame_err;
    logic o_break;

    modport master (
        output i_en, i_rx, i_start, i_data_zero,
        input  o_ready, o_frame_err, o_break
    );

    modport slave (
        input  i_en, i_rx, i_start, i_data_zero,
        output o_ready, o_frame_err, o_break
    );

endinterface

// File: rtl/uart_bit_vote.sv
// 3-sample majority voter: two stored samples plus the live line, so the
// vote resolves on the same strobe that takes the third sample.
module uart_bit_vote
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    input  logic i_rx,
    output logic o_maj
);

    logic [1:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_q <= '0;
        end else if (i_sample) begin
            hist_q <= {hist_q[0], i_rx};
        end
    end

    assign o_maj = majority3(hist_q[1], hist_q[0], i_rx);

endmodule

// File: rtl/uart_stop_check.sv
// UART receive stop-bit checker: majority-votes 1..4 stop bits and reports
// framing errors. Optional break reporting with `UART_BREAK_DETECT_EN.
module uart_stop_check
    import uart_pkg::*;
#(
    parameter int OSR       = 16,
    parameter int STOP_BITS = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_stop_check_if.slave   bus
);

    localparam int TW     = $clog2(OSR);
    localparam int BW     = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam int CENTRE = vote_centre(OSR);

    localparam logic [TW-1:0] TICK_LO   = TW'(CENTRE - VOTE_OFFSET);
    localparam logic [TW-1:0] TICK_HI   = TW'(CENTRE + VOTE_OFFSET);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(STOP_BITS - 1);

    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_stop_check: STOP_BITS must be 1..4");
    end
    if (OSR < OSR_MIN || (OSR % 2) != 0) begin : g_bad_osr
        $error("uart_stop_check: OSR must be even and >= 4");
    end

    uart_stop_state_t state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             acc_q, acc_d;
    logic             ready_q, ready_d;
    logic             frame_err_q, frame_err_d;

    logic accept;
    logic vote_strobe;
    logic vote_done;
    logic finish;
    logic vote_maj;
    logic brk_set;

    uart_bit_vote u_vote (
        .i_clk    (i_clk),
        .i_rst    (i_rst | accept),
        .i_sample (vote_strobe),
        .i_rx     (bus.i_rx),
        .o_maj    (vote_maj)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        ready_d     = 1'b0;
        frame_err_d = frame_err_q;
        accept      = 1'b0;
        vote_strobe = 1'b0;
        vote_done   = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.i_start) begin
                    accept      = 1'b1;
                    state_d     = SAMPLE;
                    tick_d      = '0;
                    bit_d       = '0;
                    acc_d       = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            SAMPLE: begin
                if (bus.i_en) begin
                    vote_strobe = (tick_q >= TICK_LO) && (tick_q <= TICK_HI);
                    vote_done   = (tick_q == TICK_HI);
                    finish      = vote_done && (bit_q == BIT_LAST);
                    if (vote_done) begin
                        acc_d = acc_q | ~vote_maj;
                    end
                    // The last stop bit ends at its vote, leaving half a bit for the next start edge.
                    if (finish) begin
                        state_d     = DONE;
                        ready_d     = 1'b1;
                        frame_err_d = acc_d | brk_set;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        bit_d  = bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            acc_q       <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_BREAK_DETECT_EN
    logic dz_q;
    logic low_q;
    logic break_q;

    // low_q stays set only while every stop-bit vote so far has been 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dz_q    <= 1'b0;
            low_q   <= 1'b0;
            break_q <= 1'b0;
        end else if (accept) begin
            dz_q    <= bus.i_data_zero;
            low_q   <= 1'b1;
            break_q <= 1'b0;
        end else if (vote_done) begin
            low_q <= low_q & ~vote_maj;
            if (finish) begin
                break_q <= brk_set;
            end
        end
    end

    assign brk_set     = dz_q & low_q & ~vote_maj;
    assign bus.o_break = break_q;
`else
    wire unused_data_zero = bus.i_data_zero;

    assign brk_set     = 1'b0;
    assign bus.o_break = 1'b0;
`endif

    assign bus.o_ready     = ready_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: doc/uart_stop_check.md
# uart_stop_check

Parametrised UART receive stop-bit checker for the `uart_rx` path, succeeding the plain stop-bit counter. It runs after the data-bit stage and times 1–4 stop bits off the oversample tick. Each stop bit is judged by a 3-sample majority vote, and a framing error is flagged if any stop bit votes low. It completes at mid-point of the last stop bit, so the start detector can catch a back-to-back frame; optionally it also reports a line break.

## Interface
- `OSR`, 16: oversample ticks per bit; even, ≥ 4.
- `STOP_BITS`, 2: number of stop bits checked; 1..4.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset; overrides every other input.
- `i_en`  in  1  oversample tick strobe, one cycle per 1/OSR bit period.
- `i_rx`  in  1  synchronised serial line.
- `i_start`  in  1  one-cycle pulse, aligned to the start of the first stop bit.
- `i_data_zero`  in  1  start and data bits of this frame were all 0; sampled with `i_start`.
- `o_ready`  out  1  one-cycle pulse: stop-bit check complete.
- `o_frame_err`  out  1  at least one stop bit voted 0; held.
- `o_break`  out  1  break detected; held.

## Operation
- States: `IDLE`, `SAMPLE`, `DONE`.
- Counters:
  - `tick_cnt`: `$clog2(OSR)` bits, counts 0..OSR-1.
  - `bit_cnt`: `$clog2(STOP_BITS)` bits (min 1), counts 0..STOP_BITS-1.
- Starting a check (`IDLE` or `DONE` with `i_start`=1):
  - go to `SAMPLE`; zero both counters;
  - clear `o_frame_err`, `o_break`, the vote register and the error accumulator;
  - latch `i_data_zero`.
- In `SAMPLE`, on each `i_en`:
  - sample `i_rx` into a 3-bit vote register when pre-increment `tick_cnt` is OSR/2-1, OSR/2 or OSR/2+1;
  - at `tick_cnt`==OSR/2+1, resolve the vote as majority(3). A result of 0 sets an internal error accumulator.
- Bit advance: on `i_en` with `tick_cnt`==OSR-1, `bit_cnt` increments and `tick_cnt` wraps to 0.
- Completion: on the `i_en` where `bit_cnt`==STOP_BITS-1 and `tick_cnt`==OSR/2+1, go to `DONE` instead. The remaining half bit is not waited out.
- `DONE` (one cycle):
  - `o_ready`=1;
  - `o_frame_err` = accumulator including the final vote;
  - next state `IDLE`.
- `i_start` in `SAMPLE` is ignored; the current check runs to completion.
- `i_start` in `DONE` is accepted: `o_ready` still pulses this cycle and the next state is `SAMPLE`. Flags clear on the following cycle.
- `i_en` low: counters and state hold; `i_rx` is not sampled.

## Timing
- Reset: state `IDLE`; counters 0; `o_ready`=0, `o_frame_err`=0, `o_break`=0.
- Reset mid-`SAMPLE`: the check is abandoned, with no `o_ready` pulse.
- `i_start` → `SAMPLE` on the next cycle; the first `i_en` counted is the one after that edge.
- Latency: `o_ready` rises on the cycle after the completing `i_en`. That is (STOP_BITS-1)·OSR + OSR/2 + 2 ticks after start, plus 1 clock.
- All outputs are registered; `o_frame_err` and `o_break` are valid in the `o_ready` cycle and held until the next accepted `i_start` or reset.

## Configuration
- `UART_BREAK_DETECT_EN` defined:
  - `o_break` is set in `DONE` iff the latched `i_data_zero`=1 and every stop-bit vote was 0;
  - a break also sets `o_frame_err`.
- `UART_BREAK_DETECT_EN` undefined: `o_break` is tied 0, `i_data_zero` is unused, and the latch register is not built.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_stop_state_t` (`IDLE`, `SAMPLE`, `DONE`);
  - the vote-tick offset constants (centre = OSR/2, ±1);
  - the `STOP_BITS` range limits, checked by an elaboration-time assertion.
- Sub-module `uart_bit_vote`:
  - 3-sample shift register plus majority function;
  - inputs clock, reset, sample strobe, `i_rx`; output majority bit;
  - reusable by the data-bit stage.

## Test plan
- Clean frame: OSR=16, STOP_BITS=2, `i_rx`=1 throughout, `i_en` every 4 clocks. Expect one `o_ready` after 26 ticks; `o_frame_err`=0.
- Glitch tolerance: the second stop bit drives `i_rx`=0 for the tick at OSR/2 only. Majority is 1, so `o_frame_err`=0.
- Framing error: STOP_BITS=1, `i_rx`=0 across ticks 7–9. Expect `o_ready` after 10 ticks with `o_frame_err`=1, held until the next `i_start`.
- Break: with `UART_BREAK_DETECT_EN`, `i_data_zero`=1 and `i_rx`=0 for all stop bits. Expect `o_break`=1 and `o_frame_err`=1. With the macro undefined, `o_break` stays 0.
- Back-to-back: `i_start` in the `DONE` cycle. Expect the `o_ready` pulse, flags clear on the next cycle, and the second check completes normally.
- Reset mid-check: `i_rst` at tick 20 of a STOP_BITS=2 check. All outputs are 0 on the next cycle, no `o_ready`, and `i_start` is accepted immediately afterwards.
